// File: rtl/tp84_rom_loader.sv
// tp84_rom_loader: routes HPS ioctl download bytes into six ROM regions,
// latches DIP switch bytes, and sequences the game core reset around a load.
module tp84_rom_loader #(
  parameter int ROM_BYTES   = 'h16800,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic [7:0]  ioctl_index,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [5:0]  rom_we,
  output logic [23:0] dip_sw,
  output logic        core_reset_n,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [24:0] ROM_END   = 25'(ROM_BYTES);
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);
  localparam logic [7:0]  IDX_ROM   = 8'd0;
  localparam logic [7:0]  IDX_DIP   = 8'd254;

  state_t      state;
  state_t      state_next;
  logic        download_prev;
  logic [24:0] byte_cnt;
  logic        overflow;
  logic [15:0] hold_cnt;
  logic        rom_start;
  logic        dl_fall;
  logic        rom_wr;
  logic        in_range;
  logic        dip_wr;
  logic        load_ok;
  logic [2:0]  region;
  logic [15:0] region_base;

  // Only a rising download of a ROM transfer restarts the loader; other
  // transfer types (DIP etc.) leave the FSM alone.
  assign rom_start = ioctl_download && !download_prev && (ioctl_index == IDX_ROM);
  assign dl_fall   = !ioctl_download && download_prev;
  assign rom_wr    = ioctl_wr && ioctl_download && (ioctl_index == IDX_ROM) && (state == LOAD);
  assign in_range  = ioctl_addr < ROM_END;
  assign dip_wr    = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr < 25'd3);
  assign load_ok   = (byte_cnt == ROM_END) && !overflow;

  // Region decode; only the low 16 bits of the base are kept because the
  // region-relative offset is truncated to 16 bits anyway.
  always_comb begin
    region      = 3'd5;
    region_base = 16'h6000;
    if (ioctl_addr < 25'h08000) begin
      region      = 3'd0;
      region_base = 16'h0000;
    end else if (ioctl_addr < 25'h0A000) begin
      region      = 3'd1;
      region_base = 16'h8000;
    end else if (ioctl_addr < 25'h0C000) begin
      region      = 3'd2;
      region_base = 16'hA000;
    end else if (ioctl_addr < 25'h0E000) begin
      region      = 3'd3;
      region_base = 16'hC000;
    end else if (ioctl_addr < 25'h16000) begin
      region      = 3'd4;
      region_base = 16'hE000;
    end
  end

  // Download edge detector; resets high so a download already in progress
  // at reset release is not mistaken for a new one.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      download_prev <= 1'b1;
    end else begin
      download_prev <= ioctl_download;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and core reset output.
  always_comb begin
    state_next   = state;
    core_reset_n = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (rom_start) state_next = LOAD;
      end
      LOAD: begin
        if (dl_fall) state_next = HOLD;
      end
      HOLD: begin
        if (rom_start) begin
          state_next = LOAD;
        end else if (hold_cnt <= 16'd1) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state == RUN) core_reset_n = 1'b1;
  end

  // Byte counter, overflow flag, hold timer and load status.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= '0;
      overflow  <= 1'b0;
      hold_cnt  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (state_next == LOAD && state != LOAD) begin
      byte_cnt  <= '0;
      overflow  <= 1'b0;
      hold_cnt  <= '0;
      load_done <= 1'b0;
    end else if (state == LOAD) begin
      if (rom_wr) begin
        if (!in_range) begin
          overflow <= 1'b1;
        end else if (byte_cnt != '1) begin
          byte_cnt <= byte_cnt + 25'd1;
        end
      end
      if (state_next == HOLD) hold_cnt <= HOLD_INIT;
    end else if (state == HOLD) begin
      if (hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;
      if (state_next == RUN) begin
        load_done <= load_ok;
        load_err  <= !load_ok;
      end
    end
  end

  // ROM write port: one-cycle strobe to the decoded region, in-range only.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      rom_we   <= '0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      rom_we <= '0;
      if (rom_wr && in_range) begin
        rom_we   <= 6'b000001 << region;
        rom_addr <= ioctl_addr[15:0] - region_base;
        rom_data <= ioctl_data;
      end
    end
  end

  // DIP switch latch; bytes arrive active-low and are stored as delivered.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      dip_sw <= 24'hFFFFFF;
    end else if (dip_wr) begin
      case (ioctl_addr[1:0])
        2'd0:    dip_sw[7:0]   <= ioctl_data;
        2'd1:    dip_sw[15:8]  <= ioctl_data;
        2'd2:    dip_sw[23:16] <= ioctl_data;
        default: dip_sw        <= dip_sw;
      endcase
    end
  end

endmodule

// File: tb/tb_tp84_rom_loader.sv
// tb_tp84_rom_loader: region-map vector table plus scoreboarded ROM write
// pulses; a second instance with a short ROM_BYTES exercises complete loads.
module tb_tp84_rom_loader;

  localparam int SMALL_BYTES = 'h100;

  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [7:0]  ioctl_index;

  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [5:0]  rom_we;
  logic [23:0] dip_sw;
  logic        core_reset_n;
  logic        load_done;
  logic        load_err;

  logic [15:0] s_rom_addr;
  logic [7:0]  s_rom_data;
  logic [5:0]  s_rom_we;
  logic [23:0] s_dip_sw;
  logic        s_core_reset_n;
  logic        s_load_done;
  logic        s_load_err;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [5:0]  we;
    logic [15:0] raddr;
  } vec_t;

  typedef struct {
    logic [5:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
    int          due;
  } exp_t;

  vec_t vecs[14];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  tp84_rom_loader dut (
    .clk_49m       (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_index   (ioctl_index),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rom_we        (rom_we),
    .dip_sw        (dip_sw),
    .core_reset_n  (core_reset_n),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  tp84_rom_loader #(.ROM_BYTES(SMALL_BYTES), .HOLD_CYCLES(16)) dut_small (
    .clk_49m       (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_index   (ioctl_index),
    .rom_addr      (s_rom_addr),
    .rom_data      (s_rom_data),
    .rom_we        (s_rom_we),
    .dip_sw        (s_dip_sw),
    .core_reset_n  (s_core_reset_n),
    .load_done     (s_load_done),
    .load_err      (s_load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Scoreboard: every rom_we pulse must match the oldest expected write,
  // arrive on its due cycle, and no expected write may go missing.
  always @(negedge clk) begin
    exp_t e;
    if (rom_we !== 6'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rom_we_unexpected act=%b req=000000 cyc=%0d", rom_we, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("rom wr cyc=%0d we=%b addr=%h data=%h", cyc, rom_we, rom_addr, rom_data);
        check("rom_we", {26'd0, rom_we}, {26'd0, e.we});
        check("rom_addr", {16'd0, rom_addr}, {16'd0, e.addr});
        check("rom_data", {24'd0, rom_data}, {24'd0, e.data});
        check("rom_latency", cyc, e.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL rom_we_missing act=000000 req=%b addr=%h", e.we, e.addr);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx,
                         input logic [5:0] we, input logic [15:0] ra);
    exp_t e;
    ioctl_wr    = 1'b1;
    ioctl_addr  = a;
    ioctl_data  = d;
    ioctl_index = idx;
    if (we != 6'd0) begin
      e.we   = we;
      e.addr = ra;
      e.data = d;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    idle(1);
  endtask

  task automatic stream(input int first, input int count, input logic [7:0] x);
    for (int i = 0; i < count; i++) begin
      wr_byte(25'(first + i), 8'(i) ^ x, 8'd0, 6'b000001, 16'(first + i));
    end
  endtask

  // Drop the download and count cycles from the edge that sees the drop
  // until core_reset_n releases.
  task automatic drop_and_time(input string tag);
    int n;
    ioctl_download = 1'b0;
    idle(1);
    n = 0;
    while (n < 64 && core_reset_n !== 1'b1) begin
      idle(1);
      n++;
    end
    check({tag, "_hold_cycles"}, n, 16);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_we"}, {26'd0, rom_we}, 32'd0);
    check({tag, "_rom_addr"}, {16'd0, rom_addr}, 32'd0);
    check({tag, "_rom_data"}, {24'd0, rom_data}, 32'd0);
    check({tag, "_dip_sw"}, {8'd0, dip_sw}, 32'h00FFFFFF);
    check({tag, "_core_reset_n"}, {31'd0, core_reset_n}, 32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{25'h00000, 8'hA0, 6'b000001, 16'h0000};
    vecs[1]  = '{25'h07FFF, 8'hA1, 6'b000001, 16'h7FFF};
    vecs[2]  = '{25'h08000, 8'hA2, 6'b000010, 16'h0000};
    vecs[3]  = '{25'h09FFF, 8'hA3, 6'b000010, 16'h1FFF};
    vecs[4]  = '{25'h0A000, 8'hA4, 6'b000100, 16'h0000};
    vecs[5]  = '{25'h0A005, 8'hA5, 6'b000100, 16'h0005};
    vecs[6]  = '{25'h0BFFF, 8'hA6, 6'b000100, 16'h1FFF};
    vecs[7]  = '{25'h0C000, 8'hA7, 6'b001000, 16'h0000};
    vecs[8]  = '{25'h0DFFF, 8'hA8, 6'b001000, 16'h1FFF};
    vecs[9]  = '{25'h0E000, 8'hA9, 6'b010000, 16'h0000};
    vecs[10] = '{25'h15FFF, 8'hAA, 6'b010000, 16'h7FFF};
    vecs[11] = '{25'h16000, 8'hAB, 6'b100000, 16'h0000};
    vecs[12] = '{25'h167FF, 8'hAC, 6'b100000, 16'h07FF};
    vecs[13] = '{25'h16800, 8'hAD, 6'b000000, 16'h0000};

    reset          = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    ioctl_index    = '0;

    idle(2);
    check_reset_outputs("por");
    reset = 1'b1;
    idle(2);

    // DIP bytes while idle; addr 3 must be dropped.
    wr_byte(25'd0, 8'h12, 8'd254, 6'd0, 16'd0);
    wr_byte(25'd1, 8'h34, 8'd254, 6'd0, 16'd0);
    wr_byte(25'd2, 8'h56, 8'd254, 6'd0, 16'd0);
    wr_byte(25'd3, 8'h78, 8'd254, 6'd0, 16'd0);
    idle(1);
    $display("dip writes dip_sw=%h", dip_sw);
    check("dip_sw", {8'd0, dip_sw}, 32'h00563412);
    check("dip_core_reset_n", {31'd0, core_reset_n}, 32'd0);

    // A non-ROM download must not start a load.
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    idle(3);
    ioctl_download = 1'b0;
    idle(30);
    check("dip_dl_no_fsm", {31'd0, core_reset_n}, 32'd0);

    // Region map table, ending with an out-of-range write.
    start_dl();
    for (int i = 0; i < 14; i++) begin
      $display("vec %0d addr=%h data=%h we=%b raddr=%h", i, vecs[i].addr, vecs[i].data,
               vecs[i].we, vecs[i].raddr);
      wr_byte(vecs[i].addr, vecs[i].data, 8'd0, vecs[i].we, vecs[i].raddr);
    end
    idle(1);
    drop_and_time("tbl");
    check("tbl_load_done", {31'd0, load_done}, 32'd0);
    check("tbl_load_err", {31'd0, load_err}, 32'd1);

    // Complete load for the small instance, short for the full-size one.
    start_dl();
    check("load_core_reset_n", {31'd0, core_reset_n}, 32'd0);
    stream(0, SMALL_BYTES, 8'h5A);
    idle(1);
    drop_and_time("full");
    check("full_small_done", {31'd0, s_load_done}, 32'd1);
    check("full_small_err", {31'd0, s_load_err}, 32'd0);
    check("full_small_crn", {31'd0, s_core_reset_n}, 32'd1);
    check("short_main_done", {31'd0, load_done}, 32'd0);
    check("short_main_err", {31'd0, load_err}, 32'd1);

    // DIP write while running leaves the core running.
    wr_byte(25'd1, 8'hAB, 8'd254, 6'd0, 16'd0);
    idle(1);
    check("dip_run_dip_sw", {8'd0, dip_sw}, 32'h0056AB12);
    check("dip_run_crn", {31'd0, core_reset_n}, 32'd1);

    // Overflow on the small instance: full count plus one extra byte.
    start_dl();
    check("reload_done_drop", {31'd0, s_load_done}, 32'd0);
    stream(0, SMALL_BYTES + 1, 8'hC3);
    idle(1);
    drop_and_time("ovf");
    check("ovf_small_done", {31'd0, s_load_done}, 32'd0);
    check("ovf_small_err", {31'd0, s_load_err}, 32'd1);

    // Restart five cycles into HOLD: core stays in reset, counter restarts.
    start_dl();
    stream(0, SMALL_BYTES, 8'h11);
    idle(1);
    ioctl_download = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("hold_crn_low", {31'd0, core_reset_n}, 32'd0);
    end
    start_dl();
    check("restart_crn_low", {31'd0, core_reset_n}, 32'd0);
    stream(0, SMALL_BYTES, 8'h22);
    idle(1);
    drop_and_time("restart");
    check("restart_small_done", {31'd0, s_load_done}, 32'd1);
    check("restart_small_err", {31'd0, s_load_err}, 32'd0);

    // Reset in the middle of a download.
    start_dl();
    stream(0, 'h50, 8'h33);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid");
    idle(1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_byte(25'('h50 + i), 8'(i), 8'd0, 6'd0, 16'd0);
    end
    check("post_rst_crn", {31'd0, core_reset_n}, 32'd0);
    ioctl_download = 1'b0;
    idle(30);
    check("post_rst_idle", {31'd0, core_reset_n}, 32'd0);
    check("post_rst_done", {31'd0, s_load_done}, 32'd0);

    // Fresh load after the aborted one.
    start_dl();
    stream(0, SMALL_BYTES, 8'h44);
    idle(1);
    drop_and_time("fresh");
    check("fresh_small_done", {31'd0, s_load_done}, 32'd1);

    idle(2);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tp84_rom_loader.md
TP84_ROM_LOADER -- requirements
Module: tp84_rom_loader

Interface
REQ-001 The module SHALL expose parameter ROM_BYTES, default 'h16800, meaning the total number of bytes in a complete ROM download.
REQ-002 The module SHALL expose parameter HOLD_CYCLES, default 16, meaning the number of clk_49m cycles core_reset_n is held low after a download ends.
REQ-003 The module SHALL have port clk_49m, input, 1 bit: the single clock for all logic.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port ioctl_download, input, 1 bit: high while an HPS transfer is in progress.
REQ-006 The module SHALL have port ioctl_wr, input, 1 bit: one-cycle byte strobe.
REQ-007 The module SHALL have port ioctl_addr, input, 25 bits: byte address within the current transfer.
REQ-008 The module SHALL have port ioctl_data, input, 8 bits: byte value.
REQ-009 The module SHALL have port ioctl_index, input, 8 bits: transfer type (0 = ROM, 254 = DIP).
REQ-010 The module SHALL have port rom_addr, output, 16 bits: byte offset within the selected region.
REQ-011 The module SHALL have port rom_data, output, 8 bits: byte to write.
REQ-012 The module SHALL have port rom_we, output, 6 bits: one-hot region write strobe.
REQ-013 The module SHALL have port dip_sw, output, 24 bits: latched DIP bytes {byte2, byte1, byte0}, active-low as delivered.
REQ-014 The module SHALL have port core_reset_n, output, 1 bit: active-low reset to the game core.
REQ-015 The module SHALL have port load_done, output, 1 bit: high when the last ROM download was complete.
REQ-016 The module SHALL have port load_err, output, 1 bit: high when the last ROM download was short or overflowed.

Function
REQ-017 The region map SHALL be: 0x00000-0x07FFF main CPU (rom_we[0]), 0x08000-0x09FFF sub CPU (rom_we[1]), 0x0A000-0x0BFFF sound CPU (rom_we[2]), 0x0C000-0x0DFFF tiles (rom_we[3]), 0x0E000-0x15FFF sprites (rom_we[4]), 0x16000-0x167FF PROMs (rom_we[5]).
REQ-018 rom_addr SHALL equal ioctl_addr minus the region base, truncated to 16 bits.
REQ-019 A ROM write (ioctl_wr and ioctl_index == 0 and ioctl_download) SHALL produce exactly one rom_we pulse, one cycle wide, one cycle after the strobe, with rom_addr/rom_data valid in the same cycle.
REQ-020 A ROM write with ioctl_addr >= ROM_BYTES SHALL produce no rom_we pulse and SHALL set an internal overflow flag.
REQ-021 A DIP write (ioctl_wr and ioctl_index == 254 and ioctl_addr < 3) SHALL update byte ioctl_addr of dip_sw one cycle later.
REQ-022 A DIP write with ioctl_addr >= 3 SHALL be ignored, and a DIP write SHALL never pulse rom_we or affect the FSM.
REQ-023 The FSM SHALL have states IDLE, LOAD, HOLD and RUN.
REQ-024 In IDLE or RUN, a rising ioctl_download with ioctl_index == 0 SHALL enter LOAD, clear the byte counter and overflow flag, and drop load_done.
REQ-025 In LOAD, each accepted ROM write SHALL increment a 25-bit byte counter, saturating at all-ones.
REQ-026 Falling ioctl_download in LOAD SHALL enter HOLD and load the hold counter with HOLD_CYCLES.
REQ-027 In HOLD, the hold counter SHALL decrement each cycle; at zero the FSM SHALL enter RUN.
REQ-028 On entering RUN, load_done SHALL be 1 if counter == ROM_BYTES and overflow is clear, and 0 otherwise; load_err SHALL be the inverse.
REQ-029 core_reset_n SHALL be 0 in IDLE, LOAD and HOLD, and 1 in RUN.
REQ-030 A new ROM download starting in HOLD SHALL return the FSM to LOAD with counters cleared.
REQ-031 A rising ioctl_download with a nonzero ioctl_index SHALL NOT change the FSM state.

Reset
REQ-032 While reset is 0, the module SHALL asynchronously force: FSM = IDLE, rom_we = 0, rom_addr = 0, rom_data = 0, dip_sw = 24'hFFFFFF, core_reset_n = 0, load_done = 0, load_err = 0, and all counters = 0.
REQ-033 A reset asserted mid-download SHALL abort the load, and after release the FSM SHALL remain in IDLE until the next rising ioctl_download.

Verification
REQ-034 Stream 0x16800 bytes (index 0), then drop ioctl_download -> six regions written; byte 0x0A005 gives rom_we = 6'b000100 and rom_addr = 0x0005; core_reset_n rises exactly 16 cycles after the drop; load_done = 1.
REQ-035 Stream only 0x10000 bytes, then drop ioctl_download -> after the hold period core_reset_n = 1, load_done = 0, load_err = 1.
REQ-036 Write a byte at ioctl_addr 0x16800 during the load -> no rom_we pulse; load_err = 1 at RUN.
REQ-037 DIP writes (index 254) to addr 0..3 with 0x12/0x34/0x56/0x78 -> dip_sw = 24'h563412; rom_we stays 0; FSM unchanged.
REQ-038 Assert reset at byte 0x5000 of a download -> all outputs at reset values; after release with download still high, FSM = IDLE and no rom_we pulses.
REQ-039 Start a new ROM download 5 cycles into HOLD -> core_reset_n stays 0, counter restarts, and a full stream then yields load_done = 1.
